// File: rtl/creek_avl_arbiter.sv
// Round-robin Avalon-MM arbiter: N Creek masters onto one DDR3 controller port,
// with in-order read response routing through a channel-ID tag FIFO.
module creek_avl_arbiter #(
  parameter int N_CHAN    = 4,
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 128,
  parameter int MAX_OUTST = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     local_init_done,
  input  logic [N_CHAN*ADDR_W-1:0] ch_address,
  input  logic [N_CHAN-1:0]        ch_read,
  input  logic [N_CHAN-1:0]        ch_write,
  input  logic [N_CHAN*DATA_W-1:0] ch_writedata,
  output logic [N_CHAN-1:0]        ch_ready,
  output logic [N_CHAN-1:0]        ch_readdatavalid,
  output logic [DATA_W-1:0]        ch_readdata,
  input  logic                     avl_ready,
  output logic [ADDR_W-1:0]        avl_address,
  output logic                     avl_read,
  output logic                     avl_write,
  output logic                     avl_burstbegin,
  output logic [DATA_W-1:0]        avl_writedata,
  input  logic                     avl_readdatavalid,
  input  logic [DATA_W-1:0]        avl_readdata,
  output logic                     rsp_orphan
);

  localparam int CW = $clog2(N_CHAN);
  localparam int FW = $clog2(MAX_OUTST);

  typedef enum logic [1:0] {S_WAIT_INIT, S_IDLE, S_ISSUE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_rr_ptr, r_grant, w_pick, w_rr_nxt, w_tag;
  logic                w_found, w_take, w_accept, w_push, w_pop, w_full, w_empty;
  logic [N_CHAN-1:0]   w_elig;
  int unsigned         w_idx;
  logic [ADDR_W-1:0]   r_avl_address, w_sel_addr;
  logic [DATA_W-1:0]   r_avl_writedata, w_sel_data, r_rdata;
  logic                r_avl_read, r_avl_write, w_sel_read, r_orphan;
  logic [N_CHAN-1:0]   r_rdv;
  logic [CW-1:0]       r_tag_mem [MAX_OUTST];
  logic [FW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [FW:0]         r_count;

  assign w_full  = (r_count == (FW+1)'(MAX_OUTST));
  assign w_empty = (r_count == '0);
  assign w_tag   = r_tag_mem[r_rd_ptr];

  // A read-and-write request is treated as a read, so it is blocked entirely while tags are exhausted.
  always_comb begin
    w_elig = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      w_elig[c] = ch_read[c] ? !w_full : ch_write[c];
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int unsigned i = 0; i < N_CHAN; i++) begin
      w_idx = 32'(r_rr_ptr) + i;
      if (w_idx >= N_CHAN) w_idx = w_idx - N_CHAN;
      if (!w_found && w_elig[w_idx[CW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[CW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_read = 1'b0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      if (w_pick == c[CW-1:0]) begin
        w_sel_addr = ch_address[c*ADDR_W +: ADDR_W];
        w_sel_data = ch_writedata[c*DATA_W +: DATA_W];
        w_sel_read = ch_read[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_WAIT_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_WAIT_INIT: if (local_init_done) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (!local_init_done) begin
          w_state_nxt = S_WAIT_INIT;
        end else if (w_found) begin
          w_take      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (avl_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_WAIT_INIT;
    endcase
  end

  always_comb begin
    ch_ready = '0;
    if (w_accept) ch_ready[r_grant] = 1'b1;
  end

  assign w_rr_nxt = (r_grant == CW'(N_CHAN - 1)) ? '0 : r_grant + 1'b1;
  assign w_push   = w_accept & r_avl_read;
  assign w_pop    = avl_readdatavalid & !w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr        <= '0;
      r_grant         <= '0;
      r_avl_address   <= '0;
      r_avl_writedata <= '0;
      r_avl_read      <= 1'b0;
      r_avl_write     <= 1'b0;
    end else if (w_take) begin
      r_grant         <= w_pick;
      r_avl_address   <= w_sel_addr;
      r_avl_writedata <= w_sel_data;
      r_avl_read      <= w_sel_read;
      r_avl_write     <= !w_sel_read;
    end else if (w_accept) begin
      r_avl_read      <= 1'b0;
      r_avl_write     <= 1'b0;
      r_rr_ptr        <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= r_grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Responses with no outstanding tag are dropped and flagged rather than routed anywhere.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdv    <= '0;
      r_rdata  <= '0;
      r_orphan <= 1'b0;
    end else begin
      r_rdv <= '0;
      if (w_pop) begin
        r_rdv[w_tag] <= 1'b1;
        r_rdata      <= avl_readdata;
      end
      if (avl_readdatavalid && w_empty) r_orphan <= 1'b1;
    end
  end

  assign avl_address      = r_avl_address;
  assign avl_read         = r_avl_read;
  assign avl_write        = r_avl_write;
  assign avl_burstbegin   = r_avl_read | r_avl_write;
  assign avl_writedata    = r_avl_writedata;
  assign ch_readdatavalid = r_rdv;
  assign ch_readdata      = r_rdata;
  assign rsp_orphan       = r_orphan;

endmodule
